rob_commit: RTL and testbench

Eight-entry reorder buffer with in-order commit for the Tomasulo core. Sits directly downstream of the decode/dispatch stage. Dispatch allocates one entry per cycle at the tail and receives the entry's tag. Functional units write results out of order over the common data bus (CDB). The block retires the head entry to the register file and rename table at most once per cycle.

---
 rtl/rob_commit_if.sv | 40 ++++
 rtl/rob_commit.sv | 91 +++++++++
 tb/tb_rob_commit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_if.sv
// Dispatch / CDB / commit bundle for the reorder buffer.
// master = dispatch + functional-unit side, slave = the ROB itself.
interface rob_commit_if #(
  parameter int TAG_W  = 3,
  parameter int REG_W  = 4,
  parameter int OPC_W  = 4,
  parameter int DATA_W = 16
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [OPC_W-1:0]  alloc_opcode;
  logic [REG_W-1:0]  alloc_dest;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              commit_valid;
  logic [REG_W-1:0]  commit_reg;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_tag;
  logic [TAG_W:0]    rob_count;
  logic              rob_full;
  logic              rob_empty;
  logic              cdb_err;

  modport master (
    output alloc_valid, alloc_opcode, alloc_dest, cdb_valid, cdb_tag, cdb_data, rd_tag,
    input  alloc_ready, alloc_tag, rd_ready, rd_data, commit_valid, commit_reg,
           commit_data, commit_tag, rob_count, rob_full, rob_empty, cdb_err
  );

  modport slave (
    input  alloc_valid, alloc_opcode, alloc_dest, cdb_valid, cdb_tag, cdb_data, rd_tag,
    output alloc_ready, alloc_tag, rd_ready, rd_data, commit_valid, commit_reg,
           commit_data, commit_tag, rob_count, rob_full, rob_empty, cdb_err
  );
endinterface

// File: rtl/rob_commit.sv
// Eight-entry reorder buffer: in-order allocate at tail, out-of-order CDB
// result writes, in-order retirement of at most one head entry per cycle.
module rob_commit #(
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = 3,
  parameter int REG_W     = 4,
  parameter int OPC_W     = 4,
  parameter int DATA_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  rob_commit_if.slave  bus
);
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0] busy_q;
  logic [ROB_DEPTH-1:0] ready_q;
  logic [OPC_W-1:0]     opcode_q [ROB_DEPTH];
  logic [REG_W-1:0]     dest_q   [ROB_DEPTH];
  logic [DATA_W-1:0]    data_q   [ROB_DEPTH];
  logic [TAG_W-1:0]     head_q;
  logic [TAG_W-1:0]     tail_q;
  logic [TAG_W:0]       count_q;
  logic                 cdb_err_q;

  logic alloc_fire;
  logic cdb_fire;
  logic commit_fire;
  logic rd_fwd;
  logic head_opcode_unused;

  assign bus.rob_full    = (count_q == FULL_CNT);
  assign bus.rob_empty   = (count_q == '0);
  assign bus.alloc_ready = !bus.rob_full;
  assign bus.alloc_tag   = tail_q;
  assign bus.rob_count   = count_q;
  assign bus.cdb_err     = cdb_err_q;

  assign alloc_fire  = bus.alloc_valid && !bus.rob_full;
  assign cdb_fire    = bus.cdb_valid && busy_q[bus.cdb_tag];
  assign commit_fire = busy_q[head_q] && ready_q[head_q];

  // A result on the CDB this cycle is visible to dispatch before it lands in the entry.
  assign rd_fwd      = bus.cdb_valid && (bus.cdb_tag == bus.rd_tag) && busy_q[bus.rd_tag];
  assign bus.rd_ready = rd_fwd || ready_q[bus.rd_tag];
  assign bus.rd_data  = rd_fwd ? bus.cdb_data : data_q[bus.rd_tag];

  // Opcode is kept per entry for debug visibility only.
  assign head_opcode_unused = ^opcode_q[head_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q           <= '0;
      ready_q          <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      cdb_err_q        <= 1'b0;
      bus.commit_valid <= 1'b0;
      bus.commit_reg   <= '0;
      bus.commit_data  <= '0;
      bus.commit_tag   <= '0;
    end else begin
      bus.commit_valid <= commit_fire;
      if (cdb_fire) ready_q[bus.cdb_tag] <= 1'b1;
      if (bus.cdb_valid && !busy_q[bus.cdb_tag]) cdb_err_q <= 1'b1;
      if (commit_fire) begin
        busy_q[head_q]  <= 1'b0;
        bus.commit_reg  <= dest_q[head_q];
        bus.commit_data <= data_q[head_q];
        bus.commit_tag  <= head_q;
        head_q          <= head_q + TAG_W'(1);
      end
      // head==tail with a busy head means full, so allocate never hits the committing slot.
      if (alloc_fire) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        tail_q          <= tail_q + TAG_W'(1);
      end
      count_q <= count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      opcode_q[tail_q] <= bus.alloc_opcode;
      dest_q[tail_q]   <= bus.alloc_dest;
    end
    if (cdb_fire) data_q[bus.cdb_tag] <= bus.cdb_data;
  end
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: reset, single op, out-of-order completion,
// full handling, pointer wrap with overlapped traffic, and CDB error.
module tb_rob_commit;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  rob_commit_if #(.TAG_W(3), .REG_W(4), .OPC_W(4), .DATA_W(16)) bus ();

  rob_commit #(.ROB_DEPTH(8), .TAG_W(3), .REG_W(4), .OPC_W(4), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid  = 1'b0;
    bus.alloc_opcode = '0;
    bus.alloc_dest   = '0;
    bus.cdb_valid    = 1'b0;
    bus.cdb_tag      = '0;
    bus.cdb_data     = '0;
    bus.rd_tag       = '0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    idle();

    // Reset, asserted away from any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_empty", 32'(bus.rob_empty), 32'd1);
    chk("rst_full", 32'(bus.rob_full), 32'd0);
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("rst_alloc_tag", 32'(bus.alloc_tag), 32'd0);
    chk("rst_count", 32'(bus.rob_count), 32'd0);
    chk("rst_commit_valid", 32'(bus.commit_valid), 32'd0);
    chk("rst_cdb_err", 32'(bus.cdb_err), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single instruction R3 -> tag 0
    bus.alloc_valid = 1'b1; bus.alloc_dest = 4'd3; bus.alloc_opcode = 4'd1;
    #1;
    chk("single_alloc_tag", 32'(bus.alloc_tag), 32'd0);
    tick();
    bus.alloc_valid = 1'b0;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd0; bus.cdb_data = 16'h1234; bus.rd_tag = 3'd0;
    #1;
    chk("single_fwd_ready", 32'(bus.rd_ready), 32'd1);
    chk("single_fwd_data", 32'(bus.rd_data), 32'h1234);
    chk("single_count1", 32'(bus.rob_count), 32'd1);
    tick();
    bus.cdb_valid = 1'b0;
    chk("single_no_early_commit", 32'(bus.commit_valid), 32'd0);
    tick();
    chk("single_commit_valid", 32'(bus.commit_valid), 32'd1);
    chk("single_commit_reg", 32'(bus.commit_reg), 32'd3);
    chk("single_commit_data", 32'(bus.commit_data), 32'h1234);
    chk("single_commit_tag", 32'(bus.commit_tag), 32'd0);
    chk("single_count0", 32'(bus.rob_count), 32'd0);
    tick();
    chk("single_pulse_end", 32'(bus.commit_valid), 32'd0);
    chk("single_reg_hold", 32'(bus.commit_reg), 32'd3);

    // Reset mid-operation with an entry in flight
    bus.alloc_valid = 1'b1; bus.alloc_dest = 4'd5;
    tick();
    bus.alloc_valid = 1'b0;
    chk("midrst_pre_tag", 32'(bus.alloc_tag), 32'd2);
    chk("midrst_pre_count", 32'(bus.rob_count), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tag", 32'(bus.alloc_tag), 32'd0);
    chk("midrst_empty", 32'(bus.rob_empty), 32'd1);
    chk("midrst_count", 32'(bus.rob_count), 32'd0);
    chk("midrst_commit_reg", 32'(bus.commit_reg), 32'd0);
    tick();
    rst = 1'b0;

    // Out-of-order completion: R1,R2,R3 at tags 0,1,2
    bus.alloc_valid = 1'b1;
    bus.alloc_dest = 4'd1; tick();
    bus.alloc_dest = 4'd2; tick();
    bus.alloc_dest = 4'd3; tick();
    bus.alloc_valid = 1'b0;
    chk("ooo_count3", 32'(bus.rob_count), 32'd3);
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd2; bus.cdb_data = 16'hAAAA; tick();
    bus.cdb_tag = 3'd1; bus.cdb_data = 16'hBBBB; tick();
    chk("ooo_hold_a", 32'(bus.commit_valid), 32'd0);
    bus.cdb_tag = 3'd0; bus.cdb_data = 16'hCCCC; tick();
    bus.cdb_valid = 1'b0;
    chk("ooo_hold_b", 32'(bus.commit_valid), 32'd0);
    tick();
    chk("ooo_c0_valid", 32'(bus.commit_valid), 32'd1);
    chk("ooo_c0_tag", 32'(bus.commit_tag), 32'd0);
    chk("ooo_c0_reg", 32'(bus.commit_reg), 32'd1);
    chk("ooo_c0_data", 32'(bus.commit_data), 32'hCCCC);
    tick();
    chk("ooo_c1_valid", 32'(bus.commit_valid), 32'd1);
    chk("ooo_c1_tag", 32'(bus.commit_tag), 32'd1);
    chk("ooo_c1_data", 32'(bus.commit_data), 32'hBBBB);
    tick();
    chk("ooo_c2_valid", 32'(bus.commit_valid), 32'd1);
    chk("ooo_c2_tag", 32'(bus.commit_tag), 32'd2);
    chk("ooo_c2_reg", 32'(bus.commit_reg), 32'd3);
    chk("ooo_c2_data", 32'(bus.commit_data), 32'hAAAA);
    tick();
    chk("ooo_done", 32'(bus.commit_valid), 32'd0);
    chk("ooo_count0", 32'(bus.rob_count), 32'd0);
    chk("ooo_no_err", 32'(bus.cdb_err), 32'd0);

    // Full: eight allocations, ninth ignored, resume after one commit
    rst_pulse();
    bus.alloc_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.alloc_dest = 4'(i);
      tick();
    end
    bus.alloc_dest = 4'd15;
    #1;
    chk("full_flag", 32'(bus.rob_full), 32'd1);
    chk("full_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    chk("full_count8", 32'(bus.rob_count), 32'd8);
    chk("full_tag_wrap", 32'(bus.alloc_tag), 32'd0);
    tick();
    chk("full_ignore_count", 32'(bus.rob_count), 32'd8);
    chk("full_ignore_tag", 32'(bus.alloc_tag), 32'd0);
    bus.alloc_valid = 1'b0;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd0; bus.cdb_data = 16'h0F0F;
    tick();
    bus.cdb_valid = 1'b0;
    chk("full_no_early_commit", 32'(bus.commit_valid), 32'd0);
    tick();
    chk("full_commit_valid", 32'(bus.commit_valid), 32'd1);
    chk("full_commit_tag", 32'(bus.commit_tag), 32'd0);
    chk("full_commit_data", 32'(bus.commit_data), 32'h0F0F);
    chk("full_count7", 32'(bus.rob_count), 32'd7);
    chk("full_reopen", 32'(bus.alloc_ready), 32'd1);
    bus.alloc_valid = 1'b1; bus.alloc_dest = 4'd9;
    #1;
    chk("full_realloc_tag", 32'(bus.alloc_tag), 32'd0);
    tick();
    bus.alloc_valid = 1'b0;
    chk("full_recount8", 32'(bus.rob_count), 32'd8);
    chk("full_again", 32'(bus.rob_full), 32'd1);

    // Wrap: 20 instructions, allocate / CDB / commit overlapped every cycle
    rst_pulse();
    for (int k = 0; k < 22; k++) begin
      bus.alloc_valid = (k < 20);
      bus.alloc_dest  = 4'(k);
      bus.cdb_valid   = (k >= 1) && (k <= 20);
      bus.cdb_tag     = 3'(k - 1);
      bus.cdb_data    = 16'h0100 + 16'(k - 1);
      bus.rd_tag      = 3'(k - 1);
      #1;
      if (k < 20) chk("wrap_alloc_tag", 32'(bus.alloc_tag), 32'(k % 8));
      if (bus.cdb_valid) begin
        chk("wrap_fwd_ready", 32'(bus.rd_ready), 32'd1);
        chk("wrap_fwd_data", 32'(bus.rd_data), 32'h0100 + 32'(k - 1));
      end
      tick();
      chk("wrap_count_le8", 32'(bus.rob_count <= 4'd8), 32'd1);
      if (k >= 2) begin
        chk("wrap_commit_valid", 32'(bus.commit_valid), 32'd1);
        chk("wrap_commit_tag", 32'(bus.commit_tag), 32'((k - 2) % 8));
        chk("wrap_commit_reg", 32'(bus.commit_reg), 32'((k - 2) % 16));
        chk("wrap_commit_data", 32'(bus.commit_data), 32'h0100 + 32'(k - 2));
      end else begin
        chk("wrap_commit_idle", 32'(bus.commit_valid), 32'd0);
      end
    end
    idle();
    chk("wrap_count0", 32'(bus.rob_count), 32'd0);

    // Error: CDB to non-busy entry 5
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd5; bus.cdb_data = 16'hDEAD;
    tick();
    bus.cdb_valid = 1'b0;
    chk("err_set", 32'(bus.cdb_err), 32'd1);
    chk("err_no_commit", 32'(bus.commit_valid), 32'd0);
    chk("err_count", 32'(bus.rob_count), 32'd0);
    bus.rd_tag = 3'd5;
    #1;
    chk("err_entry_unchanged", 32'(bus.rd_data), 32'h010D);
    tick(); tick(); tick();
    chk("err_sticky", 32'(bus.cdb_err), 32'd1);
    chk("err_still_no_commit", 32'(bus.commit_valid), 32'd0);
    rst_pulse();
    chk("err_cleared", 32'(bus.cdb_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
